// File: rtl/search_coordinator_pkg.sv
// Shared types for the gate-sequence search coordinator.
// Holds the index width, the first searched length and the FSM state encoding.
package search_coordinator_pkg;

   localparam int SEQ_INDEX_BITS = 4;

   typedef logic [SEQ_INDEX_BITS-1:0] seq_idx_t;

   localparam seq_idx_t MIN_LENGTH = seq_idx_t'(1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_LAUNCH      = 3'd1,
      ST_WAIT_RESULT = 3'd2,
      ST_WAIT_STEP   = 3'd3,
      ST_REPLAY_WAIT = 3'd4,
      ST_DONE        = 3'd5
   } coord_state_t;

endpackage

// File: rtl/search_coordinator.sv
// search_coordinator: top-level scheduler for the gate-sequence search.
// Sweeps the sequence length from MIN_LENGTH up to the latched len_limit.
// For each length it starts the generator, consumes one comparator verdict
// per sequence, and either steps the generator on or replays a match.
//
// Optional build macro SEARCH_COORD_STATS_EN adds the seq_tested output.
// seq_tested is a saturating count of the verdicts seen while busy.
//
// Handshake: the generator and comparator are driven and observed with
// single-cycle pulses, not valid/ready pairs.
// - start, can_advance and repeat_seq are registered one-cycle pulses.
//   At most one of them is high in any cycle.
// - result_valid is a one-cycle pulse that qualifies match.
// - complete is a level; only its rising edge ends a length.
// state_dbg exposes the FSM state for checkers.
module search_coordinator
   import search_coordinator_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         go,
   input  seq_idx_t     len_limit,
   output seq_idx_t     max_length,
   output logic         start,
   input  logic         complete,
   output logic         can_advance,
   output logic         repeat_seq,
   input  logic         result_valid,
   input  logic         match,
   output logic         replaying,
   output logic         busy,
   output logic         done,
   output logic         found,
   output seq_idx_t     found_length,
`ifdef SEARCH_COORD_STATS_EN
   output logic [31:0]  seq_tested,
`endif
   output coord_state_t state_dbg
);

   coord_state_t state;
   seq_idx_t     limit_q;
   logic         complete_q;
   logic         complete_rise;
   logic         go_accept;

   assign complete_rise = complete & ~complete_q;
   assign go_accept     = go && ((state == ST_IDLE) || (state == ST_DONE));
   assign busy          = (state != ST_IDLE) && (state != ST_DONE);
   assign state_dbg     = state;

   // Search FSM with registered pulse outputs and the complete edge detector.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         limit_q      <= '0;
         max_length   <= '0;
         start        <= 1'b0;
         can_advance  <= 1'b0;
         repeat_seq   <= 1'b0;
         replaying    <= 1'b0;
         done         <= 1'b0;
         found        <= 1'b0;
         found_length <= '0;
         complete_q   <= 1'b0;
      end else begin
         start       <= 1'b0;
         can_advance <= 1'b0;
         repeat_seq  <= 1'b0;
         complete_q  <= complete;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (go) begin
                  limit_q      <= len_limit;
                  done         <= 1'b0;
                  found        <= 1'b0;
                  found_length <= '0;
                  if (len_limit < MIN_LENGTH) begin
                     // Nothing to search: finish without touching the generator.
                     max_length <= '0;
                     done       <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     max_length <= MIN_LENGTH;
                     start      <= 1'b1;
                     state      <= ST_LAUNCH;
                  end
               end
            end
            ST_LAUNCH: begin
               // Treat complete as already high so a level left over from the
               // previous length cannot look like a fresh edge.
               complete_q <= 1'b1;
               state      <= ST_WAIT_RESULT;
            end
            ST_WAIT_RESULT, ST_WAIT_STEP: begin
               if (result_valid) begin
                  // A verdict wins over a simultaneous complete edge.
                  if (match) begin
                     repeat_seq <= 1'b1;
                     replaying  <= 1'b1;
                     state      <= ST_REPLAY_WAIT;
                  end else begin
                     can_advance <= 1'b1;
                     state       <= ST_WAIT_STEP;
                  end
               end else if ((state == ST_WAIT_STEP) && complete_rise) begin
                  if (max_length < limit_q) begin
                     max_length <= max_length + seq_idx_t'(1);
                     start      <= 1'b1;
                     state      <= ST_LAUNCH;
                  end else begin
                     done  <= 1'b1;
                     found <= 1'b0;
                     state <= ST_DONE;
                  end
               end
            end
            ST_REPLAY_WAIT: begin
               if (result_valid) begin
                  found        <= 1'b1;
                  done         <= 1'b1;
                  found_length <= max_length;
                  replaying    <= 1'b0;
                  state        <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SEARCH_COORD_STATS_EN
   // Saturating count of verdicts seen during a search, cleared by each accepted go.
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_tested <= '0;
      end else if (go_accept) begin
         seq_tested <= '0;
      end else if (result_valid && busy && (seq_tested != 32'hFFFF_FFFF)) begin
         seq_tested <= seq_tested + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_search_coordinator.sv
// Testbench for search_coordinator.
// Stimulus tasks push the expected pulse or done events into exp_q.
// A negedge monitor pops and compares whenever the DUT emits one.
module tb_search_coordinator;
   import search_coordinator_pkg::*;

   localparam int W = 12;
   localparam logic [3:0] K_START = 4'd1;
   localparam logic [3:0] K_ADV   = 4'd2;
   localparam logic [3:0] K_REP   = 4'd3;
   localparam logic [3:0] K_DONE  = 4'd4;

   logic         clk = 1'b0;
   logic         reset;
   logic         go;
   seq_idx_t     len_limit;
   seq_idx_t     max_length;
   logic         start;
   logic         complete;
   logic         can_advance;
   logic         repeat_seq;
   logic         result_valid;
   logic         match;
   logic         replaying;
   logic         busy;
   logic         done;
   logic         found;
   seq_idx_t     found_length;
   coord_state_t state_dbg;
`ifdef SEARCH_COORD_STATS_EN
   logic [31:0]  seq_tested;
`endif

   int checks = 0;
   int errors = 0;
   int verd_cnt = 0;
   logic [W-1:0] exp_q[$];
   logic done_prev;

   search_coordinator dut (
      .clk          (clk),
      .reset        (reset),
      .go           (go),
      .len_limit    (len_limit),
      .max_length   (max_length),
      .start        (start),
      .complete     (complete),
      .can_advance  (can_advance),
      .repeat_seq   (repeat_seq),
      .result_valid (result_valid),
      .match        (match),
      .replaying    (replaying),
      .busy         (busy),
      .done         (done),
      .found        (found),
      .found_length (found_length),
`ifdef SEARCH_COORD_STATS_EN
      .seq_tested   (seq_tested),
`endif
      .state_dbg    (state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] ev(input logic [3:0] kind, input logic flag, input logic [3:0] len);
      return {kind, flag, 3'b000, len};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic observe(input string name, input logic [W-1:0] act);
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got %0h expected nothing", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL event_%s: got %0h expected %0h", name, act, e);
         end
      end
   endtask

   // Scoreboard monitor: compares every pulse and every done rise against exp_q.
   always @(negedge clk) begin
      int npulse;
      if (reset) begin
         done_prev = 1'b0;
      end else begin
         npulse = 32'(start) + 32'(can_advance) + 32'(repeat_seq);
         if (npulse != 0) check("pulse_overlap", 32'(npulse), 32'd1);
         if (start)       observe("start", ev(K_START, 1'b0, max_length));
         if (can_advance) observe("can_advance", ev(K_ADV, 1'b0, max_length));
         if (repeat_seq)  observe("repeat_seq", ev(K_REP, 1'b0, max_length));
         if (done && !done_prev) observe("done", ev(K_DONE, found, found_length));
         done_prev = done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for a DUT output; which: 1 start, 2 can_advance, 3 repeat_seq, 4 done.
   task automatic wait_for(input string name, input int which);
      int  n = 0;
      logic seen = 1'b0;
      while (n < 50) begin
         case (which)
            1:       seen = start;
            2:       seen = can_advance;
            3:       seen = repeat_seq;
            default: seen = done;
         endcase
         if (seen) break;
         tick();
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout_%s: got no event expected event within 50 cycles", name);
      end
   endtask

   task automatic do_go(input logic [3:0] lim);
      len_limit = lim;
      go = 1'b1;
      tick();
      go = 1'b0;
      verd_cnt = 0;
   endtask

   // One comparator verdict followed by the expected registered response.
   task automatic verdict(input logic m, input logic [3:0] len);
      exp_q.push_back(ev(m ? K_REP : K_ADV, 1'b0, len));
      result_valid = 1'b1;
      match = m;
      tick();
      result_valid = 1'b0;
      match = 1'b0;
      verd_cnt++;
      wait_for(m ? "repeat_seq" : "can_advance", m ? 3 : 2);
      tick();
   endtask

   // Generator model: length L carries L+1 sequences; mlen=0 means no match.
   task automatic run_search(input logic [3:0] lim, input int mlen, input int midx);
      exp_q.push_back(ev(K_START, 1'b0, 4'd1));
      do_go(lim);
      wait_for("start", 1);
      tick();
      complete = 1'b0;
      for (int l = 1; l <= int'(lim); l++) begin
         for (int i = 0; i <= l; i++) begin
            if (l == mlen && i == midx) begin
               verdict(1'b1, l[3:0]);
               check("repeat_seq_one_cycle", 32'(repeat_seq), 32'd0);
               tick();
               check("replaying_held", 32'(replaying), 32'd1);
               check("busy_in_replay", 32'(busy), 32'd1);
               exp_q.push_back(ev(K_DONE, 1'b1, l[3:0]));
               result_valid = 1'b1;
               tick();
               result_valid = 1'b0;
               verd_cnt++;
               wait_for("done", 4);
               check("replaying_cleared", 32'(replaying), 32'd0);
               check("found_length", 32'(found_length), 32'(l));
               repeat (4) tick();
               return;
            end
            verdict(1'b0, l[3:0]);
         end
         if (l < int'(lim)) exp_q.push_back(ev(K_START, 1'b0, l[3:0] + 4'd1));
         else               exp_q.push_back(ev(K_DONE, 1'b0, 4'd0));
         complete = 1'b1;
         tick();
         if (l < int'(lim)) wait_for("start", 1);
         else               wait_for("done", 4);
         complete = 1'b0;
         tick();
      end
   endtask

   initial begin
      // Reset.
      reset = 1'b1; go = 1'b0; len_limit = '0; complete = 1'b0;
      result_valid = 1'b0; match = 1'b0;
      tick(); tick();
      check("rst_start", 32'(start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_found", 32'(found), 32'd0);
      check("rst_max_length", 32'(max_length), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;
      tick();

      // len_limit 0: done without any start.
      exp_q.push_back(ev(K_DONE, 1'b0, 4'd0));
      do_go(4'd0);
      wait_for("done", 4);
      check("zero_limit_busy", 32'(busy), 32'd0);
      check("zero_limit_max_length", 32'(max_length), 32'd0);
      repeat (3) tick();

      // Two lengths, no match.
      run_search(4'd2, 0, 0);
      check("nomatch_found", 32'(found), 32'd0);
      check("nomatch_done", 32'(done), 32'd1);
`ifdef SEARCH_COORD_STATS_EN
      check("stats_nomatch", seq_tested, 32'(verd_cnt));
`endif

      // Match on the 4th verdict (second sequence of length 2).
      run_search(4'd3, 2, 1);
      check("match_found", 32'(found), 32'd1);
      check("match_max_length", 32'(max_length), 32'd2);
`ifdef SEARCH_COORD_STATS_EN
      check("stats_match", seq_tested, 32'(verd_cnt));
`endif

      // complete held high across LAUNCH: must wait for a fresh edge.
      exp_q.push_back(ev(K_START, 1'b0, 4'd1));
      do_go(4'd2);
`ifdef SEARCH_COORD_STATS_EN
      check("stats_cleared", seq_tested, 32'd0);
`endif
      wait_for("start", 1);
      tick();
      verdict(1'b0, 4'd1);
      verdict(1'b0, 4'd1);
      exp_q.push_back(ev(K_START, 1'b0, 4'd2));
      complete = 1'b1;
      tick();
      wait_for("start", 1);
      tick();
      verdict(1'b0, 4'd2);
      repeat (5) tick();
      check("held_complete_length", 32'(max_length), 32'd2);
      check("held_complete_state", 32'(state_dbg), 32'(ST_WAIT_STEP));
      complete = 1'b0;
      tick();
      exp_q.push_back(ev(K_DONE, 1'b0, 4'd0));
      complete = 1'b1;
      tick();
      wait_for("done", 4);
      complete = 1'b0;
      repeat (3) tick();

      // Verdict and complete edge in the same WAIT_STEP cycle.
      exp_q.push_back(ev(K_START, 1'b0, 4'd1));
      do_go(4'd2);
      wait_for("start", 1);
      tick();
      verdict(1'b0, 4'd1);
      exp_q.push_back(ev(K_ADV, 1'b0, 4'd1));
      result_valid = 1'b1;
      complete = 1'b1;
      tick();
      result_valid = 1'b0;
      wait_for("can_advance", 2);
      tick();
      check("simul_length_held", 32'(max_length), 32'd1);
      check("simul_state", 32'(state_dbg), 32'(ST_WAIT_STEP));
      complete = 1'b0;
      tick();
      exp_q.push_back(ev(K_START, 1'b0, 4'd2));
      complete = 1'b1;
      tick();
      wait_for("start", 1);
      complete = 1'b0;
      tick();
      verdict(1'b0, 4'd2);
      exp_q.push_back(ev(K_DONE, 1'b0, 4'd0));
      complete = 1'b1;
      tick();
      wait_for("done", 4);
      complete = 1'b0;
      repeat (3) tick();

      // Reset during REPLAY_WAIT aborts, then go restarts at length 1.
      exp_q.push_back(ev(K_START, 1'b0, 4'd1));
      do_go(4'd2);
      wait_for("start", 1);
      tick();
      verdict(1'b1, 4'd1);
      check("replay_before_reset", 32'(replaying), 32'd1);
      reset = 1'b1;
      tick();
      check("abort_replaying", 32'(replaying), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_found", 32'(found), 32'd0);
      check("abort_max_length", 32'(max_length), 32'd0);
      check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
      reset = 1'b0;
      tick();
      exp_q.push_back(ev(K_START, 1'b0, 4'd1));
      do_go(4'd3);
      wait_for("start", 1);
      check("restart_length", 32'(max_length), 32'd1);
      repeat (4) tick();

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
